// File: rtl/mux2_arbiter.sv
// mux2_arbiter: two-requester round-robin arbiter driving a registered 2:1
// payload mux.
//
// Optional feature macro: ARB_TIMEOUT_EN. When defined, an owner holding the
// channel for TIMEOUT+1 cycles while the other side is waiting is forced to
// hand over. When undefined, no hold counter is built and ownership lasts
// until the owner releases it.
//
// Grant timing: requests sampled at edge N give a grant visible after edge N.
// The payload stage lags the grant by one further cycle.
module mux2_arbiter #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic              done,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // last_b: B was the most recent owner. served: some grant has happened
  // since reset, so a tie before any grant goes to A.
  logic last_b;
  logic served;

  logic expired;
  logic rel_a;
  logic rel_b;
  logic enter;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] hold_cnt;

  // Saturating increment: the count sticks at TIMEOUT while nobody waits.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign expired = (hold_cnt == CNT_MAX);
`else
  assign expired = 1'b0;
`endif

  // An owner lets go on done, on dropping its own request, or when its hold
  // budget is spent and the other side is waiting.
  assign rel_a = done | ~req_a | (expired & req_b);
  assign rel_b = done | ~req_b | (expired & req_a);

  // Next-state selection; done has no effect in IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_a && (!req_b || last_b || !served)) begin
          state_nxt = OWN_A;
        end else if (req_b) begin
          state_nxt = OWN_B;
        end else begin
          state_nxt = IDLE;
        end
      end
      OWN_A: begin
        if (rel_a) begin
          state_nxt = req_b ? OWN_B : IDLE;
        end
      end
      OWN_B: begin
        if (rel_b) begin
          state_nxt = req_a ? OWN_A : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A grant entry is any move into an owner state from a different state.
  assign enter = (state_nxt != state) && (state_nxt != IDLE);

  // FSM state with registered grants, select and round-robin bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      sel    <= 1'b0;
      last_b <= 1'b0;
      served <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt_a <= (state_nxt == OWN_A);
      gnt_b <= (state_nxt == OWN_B);
      if (state_nxt == OWN_A) begin
        sel <= 1'b0;
      end else if (state_nxt == OWN_B) begin
        sel <= 1'b1;
      end
      if (enter) begin
        last_b <= (state_nxt == OWN_B);
        served <= 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter: zero on every grant entry, counts each owned cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_cnt <= '0;
    end else if (enter) begin
      hold_cnt <= '0;
    end else if (state != IDLE) begin
      hold_cnt <= sat_inc(hold_cnt);
    end
  end
`endif

  // ---- payload stage: one cycle behind the grant ----
  // Payload register keeps sampling the mux in IDLE; out_valid qualifies it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_data  <= sel ? data_b : data_a;
      out_valid <= gnt_a | gnt_b;
    end
  end

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: width of each shared data channel.
REQ-002 The block SHALL have parameter TIMEOUT, default 15: maximum granted cycles before forced handover; used only when ARB_TIMEOUT_EN is defined.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have ports req_a and req_b, input, 1 each: requester A and requester B ask for the channel.
REQ-006 The block SHALL have ports data_a and data_b, input, DATA_W each: requester payloads.
REQ-007 The block SHALL have port done, input, 1: the current owner releases the channel.
REQ-008 The block SHALL have ports gnt_a and gnt_b, output, 1 each: registered grants, one-hot or both zero.
REQ-009 The block SHALL have port sel, output, 1: 2:1 mux select, 0 = A, 1 = B.
REQ-010 The block SHALL have port out_data, output, DATA_W: registered muxed payload.
REQ-011 The block SHALL have port out_valid, output, 1: out_data carries an owner's payload.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, OWN_A and OWN_B; gnt_a=1 only in OWN_A and gnt_b=1 only in OWN_B.
REQ-013 In IDLE, the FSM SHALL go to OWN_A if only req_a is high, to OWN_B if only req_b is high, and stay in IDLE if neither is high.
REQ-014 In IDLE with both requests high, the FSM SHALL grant the requester not served last, using round-robin flag last_b.
REQ-015 The last_b flag SHALL be set on entry to OWN_B and cleared on entry to OWN_A.
REQ-016 Grant latency SHALL be exactly one cycle: a request sampled at edge N gives a grant visible after edge N.
REQ-017 The owner SHALL release when done=1 or when its own request is low, sampled at an edge.
REQ-018 On release, the FSM SHALL go directly to the other owner state if the other request is high; otherwise it SHALL go to IDLE, with no dead cycle.
REQ-019 The done input SHALL be ignored in IDLE.
REQ-020 The sel output SHALL equal 0 in OWN_A and 1 in OWN_B, and SHALL hold its last value in IDLE.
REQ-021 Each cycle, out_data SHALL be registered as (sel ? data_b : data_a) and out_valid as (gnt_a | gnt_b), giving one cycle of lag behind the grant.
REQ-022 In IDLE, out_data SHALL keep sampling the mux, and out_valid=0 marks it as don't-care.
REQ-023 If done and the other request are high in the same cycle, handover SHALL take priority over return to IDLE.

Reset
REQ-024 While resetn=0, state SHALL be IDLE and gnt_a, gnt_b, sel, out_data, out_valid and last_b SHALL all be 0, immediately and without a clock edge.
REQ-025 Reset asserted mid-grant SHALL drop the grant at once.
REQ-026 After resetn rises, the first edge SHALL evaluate requests normally, with A winning a tie.

Configuration
REQ-027 With macro ARB_TIMEOUT_EN defined, a hold counter of ceil(log2(TIMEOUT+1)) bits SHALL clear on every grant entry and increment each owned cycle.
REQ-028 With ARB_TIMEOUT_EN defined, when the counter equals TIMEOUT and the other request is high, the owner SHALL be forcibly released with handover per REQ-018.
REQ-029 With ARB_TIMEOUT_EN defined, when the counter equals TIMEOUT and the other request is low, the counter SHALL saturate and ownership SHALL continue.
REQ-030 Without ARB_TIMEOUT_EN, no counter SHALL exist and ownership SHALL persist until REQ-017 release.

Verification
REQ-031 The bench SHALL cover: req_a=1 only, data_a=8'h3C -> gnt_a=1 next cycle, sel=0, then out_data=8'h3C and out_valid=1 one cycle later.
REQ-032 The bench SHALL cover: req_a=req_b=1 from reset -> OWN_A first; done pulse -> OWN_B on the next edge with no IDLE cycle and sel=1.
REQ-033 The bench SHALL cover: alternating ties over 4 grants -> order A, B, A, B.
REQ-034 The bench SHALL cover: resetn=0 while in OWN_B -> gnt_b=0, sel=0 and out_valid=0 before the next edge.
REQ-035 The bench SHALL cover: ARB_TIMEOUT_EN with TIMEOUT=15, A holds and B requests -> gnt_b after exactly 16 owned A cycles; with B idle -> A keeps the grant.
REQ-036 The bench SHALL cover: owner drops its request while done=0 and the other is idle -> IDLE, both grants 0, out_valid=0 one cycle later.
